// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package rf_pkg;
    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    wd;
    } wb_req_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    wd;
    } lu_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering long-latency results until the write port is free.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  lu_entry_t din,
    output lu_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    lu_entry_t   mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign head  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered long-latency results, and tracks registers with pending LU results.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0]    pipe_wd,
    input  logic                     lu_issue,
    input  logic [ADDRESS_WIDTH-1:0] lu_issue_rd,
    input  logic                     lu_valid,
    input  logic [ADDRESS_WIDTH-1:0] lu_rd,
    input  logic [DATA_WIDTH-1:0]    lu_wd,
    output logic                     lu_ready,
    input  logic [ADDRESS_WIDTH-1:0] dec_rs1,
    input  logic [ADDRESS_WIDTH-1:0] dec_rs2,
    input  logic [ADDRESS_WIDTH-1:0] dec_rd,
    output logic                     hazard,
    output logic                     wb_stall,
    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_ad,
    output logic [DATA_WIDTH-1:0]    rf_wd
);
    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE = 1;

    lu_entry_t       head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            pipe_go;
    logic            starved;
    logic [CW-1:0]   starve_cnt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    wb_req_t         sel;

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ('{rd: lu_rd, wd: lu_wd}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign starved  = (starve_cnt == CNT_MAX);
    assign wb_stall = starved && !rst;
    assign lu_ready = !full && !rst;
    assign push     = lu_valid && lu_ready;
    // A pipeline write to x0 is treated as idle so a buffered result can drain.
    assign pipe_go  = pipe_we && !wb_stall && (pipe_rd != '0);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sel = '{we: 1'b0, rd: '0, wd: '0};
        pop = 1'b0;
        if (!rst) begin
            if (pipe_go) begin
                sel = '{we: 1'b1, rd: pipe_rd, wd: pipe_wd};
            end else if (!empty) begin
                pop = 1'b1;
                sel = '{we: (head.rd != '0), rd: head.rd, wd: head.wd};
            end
        end
    end

    assign rf_we = sel.we;
    assign rf_ad = sel.rd;
    assign rf_wd = sel.wd;

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.rd] = 1'b0;
        if (lu_issue && (lu_issue_rd != '0)) busy_next[lu_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            starve_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (pop) begin
                starve_cnt <= '0;
            end else if (!empty && !starved) begin
                starve_cnt <= starve_cnt + CNT_ONE;
            end
        end
    end

    assign hazard = !rst && (busy[dec_rs1] || busy[dec_rs2] || busy[dec_rd]);

    // The pipeline must honour wb_stall; a write presented anyway is dropped.
    assert property (@(posedge clk) disable iff (rst) !(pipe_we && wb_stall));
endmodule
